rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 17 +
 rtl/rob.sv | 204 ++++++++++++++++++++
 tb/tb_rob.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared widths and issue-kind encodings for the reorder buffer.
package rob_pkg;

  localparam int ROB_ADDR_LEN = 4;
  localparam int DATA_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;

  localparam logic [1:0] KIND_REG    = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_STORE  = 2'b10;

  // Circular pointer advance; 4-bit arithmetic wraps 15 -> 0 naturally.
  function automatic logic [ROB_ADDR_LEN-1:0] rob_inc(input logic [ROB_ADDR_LEN-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order completion via CDB,
// in-order single-entry commit with mispredict flush.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_kind,
  input  logic [REG_ADDR_LEN-1:0] issue_rd,
  output logic                    rob_full,
  output logic [ROB_ADDR_LEN-1:0] alloc_rob_num,
  input  logic                    cdb_valid,
  input  logic [ROB_ADDR_LEN-1:0] cdb_rob_num,
  input  logic [DATA_LEN-1:0]     cdb_data,
  input  logic                    cdb_mispred,
  input  logic [ROB_ADDR_LEN-1:0] q1_rob_num,
  input  logic [ROB_ADDR_LEN-1:0] q2_rob_num,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [DATA_LEN-1:0]     q1_data,
  output logic [DATA_LEN-1:0]     q2_data,
  output logic                    has_from_rob,
  output logic [REG_ADDR_LEN-1:0] dest_reg_num,
  output logic [DATA_LEN-1:0]     in_reg_data,
  output logic                    commit_store,
  output logic                    has_misbranch,
  output logic [DATA_LEN-1:0]     redirect_pc
);

  logic [ROB_ADDR_LEN-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR_LEN:0]   count_q, count_d;

  logic                    valid_q   [ROB_DEPTH];
  logic                    valid_d   [ROB_DEPTH];
  logic                    ready_q   [ROB_DEPTH];
  logic                    ready_d   [ROB_DEPTH];
  logic                    mispred_q [ROB_DEPTH];
  logic                    mispred_d [ROB_DEPTH];
  logic [1:0]              kind_q    [ROB_DEPTH];
  logic [1:0]              kind_d    [ROB_DEPTH];
  logic [REG_ADDR_LEN-1:0] rd_q      [ROB_DEPTH];
  logic [REG_ADDR_LEN-1:0] rd_d      [ROB_DEPTH];
  logic [DATA_LEN-1:0]     data_q    [ROB_DEPTH];
  logic [DATA_LEN-1:0]     data_d    [ROB_DEPTH];

  logic                    has_from_rob_q, has_from_rob_d;
  logic [REG_ADDR_LEN-1:0] dest_reg_num_q, dest_reg_num_d;
  logic [DATA_LEN-1:0]     in_reg_data_q, in_reg_data_d;
  logic                    commit_store_q, commit_store_d;
  logic                    has_misbranch_q, has_misbranch_d;
  logic [DATA_LEN-1:0]     redirect_pc_q, redirect_pc_d;

  logic do_issue, do_cdb, do_commit, do_flush;

  assign rob_full      = (count_q == (ROB_ADDR_LEN+1)'(ROB_DEPTH));
  assign alloc_rob_num = tail_q;

  assign has_from_rob  = has_from_rob_q;
  assign dest_reg_num  = dest_reg_num_q;
  assign in_reg_data   = in_reg_data_q;
  assign commit_store  = commit_store_q;
  assign has_misbranch = has_misbranch_q;
  assign redirect_pc   = redirect_pc_q;

  // Operand lookup with same-cycle CDB bypass; forced to 0 while reset is held
  // so a live CDB cannot leak through during reset.
  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    q2_ready = 1'b0;
    q2_data  = '0;
    if (rst) begin
      if (cdb_valid && (cdb_rob_num == q1_rob_num)) begin
        q1_ready = 1'b1;
        q1_data  = cdb_data;
      end else begin
        q1_ready = valid_q[q1_rob_num] && ready_q[q1_rob_num];
        q1_data  = data_q[q1_rob_num];
      end
      if (cdb_valid && (cdb_rob_num == q2_rob_num)) begin
        q2_ready = 1'b1;
        q2_data  = cdb_data;
      end else begin
        q2_ready = valid_q[q2_rob_num] && ready_q[q2_rob_num];
        q2_data  = data_q[q2_rob_num];
      end
    end
  end

  // Next-state: allocate at tail, complete from CDB, retire head, flush on mispredict.
  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    valid_d         = valid_q;
    ready_d         = ready_q;
    mispred_d       = mispred_q;
    kind_d          = kind_q;
    rd_d            = rd_q;
    data_d          = data_q;
    has_from_rob_d  = 1'b0;
    commit_store_d  = 1'b0;
    has_misbranch_d = 1'b0;
    dest_reg_num_d  = dest_reg_num_q;
    in_reg_data_d   = in_reg_data_q;
    redirect_pc_d   = redirect_pc_q;

    do_issue  = rdy && issue_valid && !rob_full;
    do_cdb    = rdy && cdb_valid && valid_q[cdb_rob_num];
    do_commit = rdy && (count_q != '0) && ready_q[head_q];
    do_flush  = do_commit && (kind_q[head_q] == KIND_BRANCH) && mispred_q[head_q];

    if (do_cdb) begin
      ready_d[cdb_rob_num]   = 1'b1;
      data_d[cdb_rob_num]    = cdb_data;
      mispred_d[cdb_rob_num] = cdb_mispred;
    end

    if (do_issue) begin
      valid_d[tail_q]   = 1'b1;
      ready_d[tail_q]   = 1'b0;
      mispred_d[tail_q] = 1'b0;
      kind_d[tail_q]    = issue_kind;
      rd_d[tail_q]      = issue_rd;
      tail_d            = rob_inc(tail_q);
    end

    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      head_d          = rob_inc(head_q);
      case (kind_q[head_q])
        KIND_REG: begin
          if (rd_q[head_q] != '0) begin
            has_from_rob_d = 1'b1;
            dest_reg_num_d = rd_q[head_q];
            in_reg_data_d  = data_q[head_q];
          end
        end
        KIND_STORE: commit_store_d = 1'b1;
        default: ;
      endcase
    end

    count_d = count_q + {{ROB_ADDR_LEN{1'b0}}, do_issue}
                      - {{ROB_ADDR_LEN{1'b0}}, do_commit};

    // Mispredict wipes everything younger, including anything issued this cycle.
    if (do_flush) begin
      has_misbranch_d = 1'b1;
      redirect_pc_d   = data_q[head_q];
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_d[i] = 1'b0;
        ready_d[i] = 1'b0;
      end
    end
  end

  // State registers; rdy low holds entries and pointers, commit pulses drop to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      has_from_rob_q  <= 1'b0;
      dest_reg_num_q  <= '0;
      in_reg_data_q   <= '0;
      commit_store_q  <= 1'b0;
      has_misbranch_q <= 1'b0;
      redirect_pc_q   <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        ready_q[i]   <= 1'b0;
        mispred_q[i] <= 1'b0;
        kind_q[i]    <= '0;
        rd_q[i]      <= '0;
        data_q[i]    <= '0;
      end
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      has_from_rob_q  <= has_from_rob_d;
      dest_reg_num_q  <= dest_reg_num_d;
      in_reg_data_q   <= in_reg_data_d;
      commit_store_q  <= commit_store_d;
      has_misbranch_q <= has_misbranch_d;
      redirect_pc_q   <= redirect_pc_d;
      valid_q         <= valid_d;
      ready_q         <= ready_d;
      mispred_q       <= mispred_d;
      kind_q          <= kind_d;
      rd_q            <= rd_d;
      data_q          <= data_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer: expected commit pulses are queued
// at stimulus time and popped by a monitor whenever the DUT pulses a commit.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_kind = 2'b00;
  logic [4:0]  issue_rd = '0;
  logic        rob_full;
  logic [3:0]  alloc_rob_num;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_rob_num = '0;
  logic [31:0] cdb_data = '0;
  logic        cdb_mispred = 1'b0;
  logic [3:0]  q1_rob_num = '0;
  logic [3:0]  q2_rob_num = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        has_from_rob;
  logic [4:0]  dest_reg_num;
  logic [31:0] in_reg_data;
  logic        commit_store;
  logic        has_misbranch;
  logic [31:0] redirect_pc;

  typedef struct {
    logic        rf;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        st;
    logic        mb;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .rob_full(rob_full), .alloc_rob_num(alloc_rob_num),
    .cdb_valid(cdb_valid), .cdb_rob_num(cdb_rob_num), .cdb_data(cdb_data),
    .cdb_mispred(cdb_mispred),
    .q1_rob_num(q1_rob_num), .q2_rob_num(q2_rob_num),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_data(q1_data), .q2_data(q2_data),
    .has_from_rob(has_from_rob), .dest_reg_num(dest_reg_num), .in_reg_data(in_reg_data),
    .commit_store(commit_store), .has_misbranch(has_misbranch), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rf(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e = '{rf: 1'b1, rd: rd, data: d, st: 1'b0, mb: 1'b0, pc: 32'h0};
    sb.push_back(e);
  endtask

  task automatic push_st();
    exp_t e;
    e = '{rf: 1'b0, rd: 5'd0, data: 32'h0, st: 1'b1, mb: 1'b0, pc: 32'h0};
    sb.push_back(e);
  endtask

  task automatic push_mb(input logic [31:0] pc);
    exp_t e;
    e = '{rf: 1'b0, rd: 5'd0, data: 32'h0, st: 1'b0, mb: 1'b1, pc: pc};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_kind  = k;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] n, input logic [31:0] d, input logic mp);
    cdb_valid   = 1'b1;
    cdb_rob_num = n;
    cdb_data    = d;
    cdb_mispred = mp;
    tick();
    cdb_valid   = 1'b0;
    cdb_mispred = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rob_full"}, {31'b0, rob_full}, 32'h0);
    chk({tag, "_alloc"}, {28'b0, alloc_rob_num}, 32'h0);
    chk({tag, "_q1_ready"}, {31'b0, q1_ready}, 32'h0);
    chk({tag, "_q1_data"}, q1_data, 32'h0);
    chk({tag, "_q2_ready"}, {31'b0, q2_ready}, 32'h0);
    chk({tag, "_pulses"}, {29'b0, has_from_rob, commit_store, has_misbranch}, 32'h0);
    chk({tag, "_dest"}, {27'b0, dest_reg_num}, 32'h0);
    chk({tag, "_in_data"}, in_reg_data, 32'h0);
    chk({tag, "_redirect"}, redirect_pc, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  // Monitor: every commit pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst && (has_from_rob || commit_store || has_misbranch)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit rf=%0b st=%0b mb=%0b rd=%0d data=0x%0h t=%0t",
                 has_from_rob, commit_store, has_misbranch, dest_reg_num, in_reg_data, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_rf", {31'b0, has_from_rob}, {31'b0, mon_e.rf});
        chk("commit_store", {31'b0, commit_store}, {31'b0, mon_e.st});
        chk("commit_misbranch", {31'b0, has_misbranch}, {31'b0, mon_e.mb});
        if (mon_e.rf) begin
          chk("commit_dest", {27'b0, dest_reg_num}, {27'b0, mon_e.rd});
          chk("commit_data", in_reg_data, mon_e.data);
        end
        if (mon_e.mb) chk("redirect_pc", redirect_pc, mon_e.pc);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b1;

    // Out-of-order completion, in-order commit
    for (int i = 0; i < 3; i++) begin
      chk("t1_alloc", {28'b0, alloc_rob_num}, i);
      issue(2'b00, 5'(i + 1));
    end
    push_rf(5'd1, 32'h10);
    push_rf(5'd2, 32'h20);
    push_rf(5'd3, 32'h30);
    cdb(4'd2, 32'h30, 1'b0);
    cdb(4'd0, 32'h10, 1'b0);
    cdb(4'd1, 32'h20, 1'b0);
    repeat (4) tick();
    chk("t1_alloc_after", {28'b0, alloc_rob_num}, 32'd3);
    chk("t1_not_full", {31'b0, rob_full}, 32'h0);

    // Full boundary
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("t2_not_full_yet", {31'b0, rob_full}, 32'h0);
      issue(2'b00, 5'(i + 1));
    end
    chk("t2_full", {31'b0, rob_full}, 32'h1);
    chk("t2_alloc_wrap", {28'b0, alloc_rob_num}, 32'h0);
    issue(2'b00, 5'd20);
    chk("t2_17th_full", {31'b0, rob_full}, 32'h1);
    chk("t2_17th_alloc", {28'b0, alloc_rob_num}, 32'h0);
    push_rf(5'd1, 32'h100);
    cdb(4'd0, 32'h100, 1'b0);
    chk("t2_full_before_commit", {31'b0, rob_full}, 32'h1);
    issue(2'b00, 5'd21);
    chk("t2_full_after_commit", {31'b0, rob_full}, 32'h0);
    chk("t2_no_bypass_alloc", {28'b0, alloc_rob_num}, 32'h0);
    tick();

    // Mispredict flush with younger entries pending
    do_reset();
    issue(2'b00, 5'd5);
    issue(2'b01, 5'd0);
    issue(2'b00, 5'd6);
    issue(2'b10, 5'd0);
    push_rf(5'd5, 32'h55);
    push_mb(32'h1000);
    cdb(4'd0, 32'h55, 1'b0);
    cdb(4'd1, 32'h1000, 1'b1);
    issue_valid = 1'b1;
    issue_kind  = 2'b00;
    issue_rd    = 5'd7;
    cdb(4'd2, 32'h66, 1'b0);
    issue_valid = 1'b0;
    chk("t3_alloc_zero", {28'b0, alloc_rob_num}, 32'h0);
    chk("t3_not_full", {31'b0, rob_full}, 32'h0);
    repeat (3) tick();

    // Lookup: bypass, stored result, pending entry
    q1_rob_num  = 4'd5;
    q2_rob_num  = 4'd4;
    cdb_valid   = 1'b1;
    cdb_rob_num = 4'd5;
    cdb_data    = 32'hABCD;
    #1;
    chk("t4_bypass_ready", {31'b0, q1_ready}, 32'h1);
    chk("t4_bypass_data", q1_data, 32'hABCD);
    chk("t4_other_not_ready", {31'b0, q2_ready}, 32'h0);
    cdb_valid = 1'b0;
    tick();
    issue(2'b00, 5'd8);
    issue(2'b00, 5'd9);
    cdb(4'd1, 32'h99, 1'b0);
    q1_rob_num = 4'd0;
    q2_rob_num = 4'd1;
    #1;
    chk("t4_stored_ready", {31'b0, q2_ready}, 32'h1);
    chk("t4_stored_data", q2_data, 32'h99);
    chk("t4_pending", {31'b0, q1_ready}, 32'h0);
    push_rf(5'd8, 32'h88);
    push_rf(5'd9, 32'h99);
    cdb(4'd0, 32'h88, 1'b0);
    repeat (3) tick();

    // rd=0 commits silently, then store pulses once
    chk("t5_alloc", {28'b0, alloc_rob_num}, 32'd2);
    issue(2'b00, 5'd0);
    issue(2'b10, 5'd0);
    push_st();
    cdb(4'd3, 32'h0, 1'b0);
    cdb(4'd2, 32'h77, 1'b0);
    repeat (4) tick();

    // Async reset mid-stream with 8 entries and a live CDB
    for (int i = 0; i < 8; i++) issue(2'b00, 5'(i + 10));
    cdb(4'd6, 32'h66, 1'b0);
    chk("t6_alloc_before", {28'b0, alloc_rob_num}, 32'd12);
    cdb_valid   = 1'b1;
    cdb_rob_num = 4'd5;
    cdb_data    = 32'h1234;
    q1_rob_num  = 4'd5;
    q2_rob_num  = 4'd6;
    rst = 1'b0;
    #1;
    check_all_zero("t6_rst");
    cdb_valid = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_alloc_after_release", {28'b0, alloc_rob_num}, 32'h0);
    issue(2'b00, 5'd1);
    chk("t6_alloc_one", {28'b0, alloc_rob_num}, 32'h1);
    rdy = 1'b0;
    issue(2'b00, 5'd2);
    chk("t6_rdy_freeze", {28'b0, alloc_rob_num}, 32'h1);
    rdy = 1'b1;

    repeat (5) tick();
    chk("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
